// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: run/halt/single-step controller with PC breakpoint for the
// 4-bit core, plus a data-memory arbiter that lets a host debug port read and
// write the 16x4 data memory while the core is halted.
`timescale 1ns/1ps
module cpu_debug_ctrl #(
    parameter int PM_AW  = 8,
    parameter int DM_AW  = 4,
    parameter int DM_DW  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_run,
    input  logic              host_halt,
    input  logic              host_step,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_en,
    input  logic [PM_AW-1:0]  bp_addr,
    input  logic [PM_AW-1:0]  pm_address,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    input  logic [DM_AW-1:0]  cpu_dm_addr,
    input  logic [DM_DW-1:0]  cpu_dm_data,
    input  logic              cpu_dm_wren,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [DM_AW-1:0]  host_addr,
    input  logic [DM_DW-1:0]  host_wdata,
    output logic              host_gnt,
    output logic              host_ack,
    output logic [DM_DW-1:0]  host_rdata,
    input  logic [DM_DW-1:0]  dm_q,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DM_DW-1:0]  dm_data,
    output logic              dm_wren
);

    localparam logic [2:0] S_HALT  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_H_ACC = 3'd3;
    localparam logic [2:0] S_H_ACK = 3'd4;

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [STEP_W-1:0] step_cnt;
    logic              bp_skip;
    logic              bp_match;
    logic              executing;

    // bp_skip masks the breakpoint for the first instruction after a resume,
    // so the instruction that caused the halt can actually execute.
    assign bp_match  = bp_en && (pm_address == bp_addr) && !bp_skip;
    assign executing = (state == S_RUN) || (state == S_STEP);
    assign cpu_en    = executing && !bp_match;
    assign halted    = (state == S_HALT) || (state == S_H_ACC) || (state == S_H_ACK);
    assign host_gnt  = (state == S_H_ACC);
    assign host_ack  = (state == S_H_ACK);

    // Memory port mux: the host owns the memory only in H_ACC; core writes are gated by cpu_en.
    always_comb begin
        dm_addr = cpu_dm_addr;
        dm_data = cpu_dm_data;
        dm_wren = cpu_dm_wren && cpu_en;
        if (state == S_H_ACC) begin
            dm_addr = host_addr;
            dm_data = host_wdata;
            dm_wren = host_we;
        end
    end

    // Control FSM: command acceptance in HALT, step counting, breakpoint halts and host accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_HALT;
            step_cnt   <= '0;
            bp_hit     <= 1'b0;
            bp_skip    <= 1'b0;
            host_rdata <= '0;
        end else begin
            case (state)
                S_HALT: begin
                    if (host_req) begin
                        state <= S_H_ACC;
                    end else if (host_step && (step_count != '0)) begin
                        state    <= S_STEP;
                        step_cnt <= step_count;
                        bp_hit   <= 1'b0;
                    end else if (host_run) begin
                        state  <= S_RUN;
                        bp_hit <= 1'b0;
                    end
                end
                S_RUN, S_STEP: begin
                    if (bp_match) begin
                        state    <= S_HALT;
                        bp_hit   <= 1'b1;
                        bp_skip  <= 1'b1;
                        step_cnt <= '0;
                    end else begin
                        bp_skip <= 1'b0;
                        if (state == S_STEP) begin
                            step_cnt <= step_cnt - STEP_ONE;
                        end
                        if ((state == S_STEP) && (step_cnt == STEP_ONE)) begin
                            state <= S_HALT;
                        end else if (host_halt) begin
                            state <= S_HALT;
                        end
                    end
                end
                S_H_ACC: begin
                    host_rdata <= dm_q;
                    state      <= S_H_ACK;
                end
                S_H_ACK: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
